fpu_addsub_arbiter: RTL and testbench
=====================================

FPU_ADDSUB_ARBITER -- requirements
Module: fpu_addsub_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, IEEE-754 single.
REQ-002 SHALL have parameter UNIT_LAT, default 1, legal range 1..15: cycles from stable unit operands to sampled unit result.
REQ-003 SHALL have one clock and an asynchronous active-low reset, as listed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  grant; request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
- req0_op / req1_op  in  1  0 = add, 1 = subtract
- unit_a, unit_b  out  XLEN  registered operands to the shared add/sub datapath
- unit_op  out  1  selects adder (0) or subtractor (1) result
- unit_result  in  XLEN  datapath result
- unit_overflow, unit_underflow, unit_exception  in  1  datapath flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_result  out  XLEN  captured result
- rsp_flags  out  3  {exception, underflow, overflow} captured with the result
- sticky_flags  out  3  OR of every captured rsp_flags since the last clear
- sticky_clr  in  1  clears sticky_flags
- busy  out  1  high in any state other than IDLE

Function
REQ-004 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one operation in flight at a time.
REQ-005 IDLE: if any reqN_valid, SHALL assert exactly one reqN_ready combinationally in the same cycle, latch operands, op and id into unit_a/unit_b/unit_op/rsp_id, load the wait counter with UNIT_LAT, and go to WAIT.
REQ-006 Both requests valid in IDLE: SHALL grant the port not equal to last_grant; single valid: SHALL grant that port; last_grant SHALL update on every grant.
REQ-007 reqN_ready SHALL be 0 in WAIT and RESP, and whenever reqN_valid is 0.
REQ-008 WAIT: counter SHALL decrement each cycle; in the cycle it equals 1 SHALL capture unit_result into rsp_result and the three flags into rsp_flags, then go to RESP.
REQ-009 unit_a, unit_b and unit_op SHALL stay constant from grant until leaving WAIT.
REQ-010 RESP: rsp_valid SHALL be 1; rsp_result, rsp_flags and rsp_id SHALL hold while rsp_ready is 0; when rsp_valid and rsp_ready are both 1, SHALL go to IDLE.
REQ-011 Latency: grant in cycle t SHALL give rsp_valid first high in cycle t+1+UNIT_LAT; with rsp_ready tied to 1, the next grant SHALL be no earlier than cycle t+2+UNIT_LAT.
REQ-012 sticky_flags SHALL OR in rsp_flags at capture; sticky_clr SHALL zero it; if sticky_clr coincides with a capture, sticky_flags SHALL equal the new captured flags.
REQ-013 The block SHALL NOT modify operand or result bits; arithmetic belongs to the datapath.

Reset
REQ-014 On rst_n low, regardless of state: FSM = IDLE, last_grant = 1 (port 0 wins the first tie), counter = 0; unit_a, unit_b, rsp_result = 0; unit_op, rsp_id = 0; rsp_flags, sticky_flags = 0; rsp_valid, busy, req0_ready, req1_ready = 0.
REQ-015 Reset during WAIT or RESP SHALL discard the in-flight operation without emitting a response.

Structure
REQ-016 Shared package fpu_ctrl_pkg SHALL hold the FSM state encoding, op encoding (ADD = 0, SUB = 1) and flag bit indices (OVF = 0, UDF = 1, EXC = 2).
REQ-017 Two-requester round-robin grant logic SHALL be a sub-module named fpu_rr_arb2.

Verification
REQ-018 Bench SHALL model the datapath with UNIT_LAT = 1 and UNIT_LAT = 4, and cover these scenarios:
- req0 add 0x3F800000 + 0x40000000, rsp_ready = 1 -> rsp_result 0x40400000, rsp_id 0, rsp_valid at t+1+UNIT_LAT
- req1 sub 0x40400000 - 0x3F800000 -> rsp_result 0x40000000, rsp_id 1, rsp_flags 0
- Both valid for the first time after reset, three ops each -> grant order 0,1,0,1,0,1
- rsp_ready low for 5 cycles in RESP -> rsp_* stable, no new grant, busy = 1 throughout
- Model asserts unit_overflow on op 1, op 2 clean, sticky_clr pulsed with op 3 capture (unit_underflow) -> sticky_flags 001, 001, then 010
- rst_n low mid-WAIT -> all outputs at reset values, no rsp_valid; next request is served normally

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings for the FP add/sub request arbiter: FSM states, op codes
// and flag bit positions.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_OVF = 0;
    localparam int FLAG_UDF = 1;
    localparam int FLAG_EXC = 2;

    // Wide enough for the largest unit latency (15)
    localparam int CNT_W = 4;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-requester round-robin grant: a tie goes to the port that did not win
// last; the last winner is remembered on every grant.
import fpu_ctrl_pkg::*;

module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_valid == 2'b11) o_grant = r_last ? 2'b01 : 2'b10;
            else                  o_grant = i_valid;
        end
    end

    // Reset to port 1 so that port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_last <= 1'b1;
        else if (|o_grant)  r_last <= o_grant[1];
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one add/sub datapath between two requesters: grants one op at a time,
// waits UNIT_LAT cycles, then holds the sampled result on a valid/ready port.
import fpu_ctrl_pkg::*;

module fpu_addsub_arbiter #(
    parameter int XLEN     = 32,
    parameter int UNIT_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic            req0_op,
    input  logic            req1_op,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic            unit_op,
    input  logic [XLEN-1:0] unit_result,
    input  logic            unit_overflow,
    input  logic            unit_underflow,
    input  logic            unit_exception,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic [2:0]      rsp_flags,
    output logic [2:0]      sticky_flags,
    input  logic            sticky_clr,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(UNIT_LAT);

    fsm_state_e       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_unit_a, r_unit_b, r_rsp_result;
    logic             r_unit_op, r_rsp_id;
    logic [2:0]       r_rsp_flags, r_sticky;
    logic [1:0]       w_grant;
    logic             w_arb_en, w_capture;
    logic [2:0]       w_flags;

    // Gating with rst_n keeps both readies low while reset is held
    assign w_arb_en  = rst_n && (r_state == ST_IDLE);
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

    fpu_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_arb_en),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    always_comb begin
        w_flags           = 3'b000;
        w_flags[FLAG_OVF] = unit_overflow;
        w_flags[FLAG_UDF] = unit_underflow;
        w_flags[FLAG_EXC] = unit_exception;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|w_grant)  w_next = ST_WAIT;
            ST_WAIT: if (w_capture) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (r_state == ST_RESP);
        busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_unit_a  <= '0;
            r_unit_b  <= '0;
            r_unit_op <= 1'b0;
            r_rsp_id  <= 1'b0;
        end else if (|w_grant) begin
            r_cnt     <= LAT_LD;
            r_unit_a  <= w_grant[1] ? req1_a  : req0_a;
            r_unit_b  <= w_grant[1] ? req1_b  : req0_b;
            r_unit_op <= w_grant[1] ? req1_op : req0_op;
            r_rsp_id  <= w_grant[1];
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 3'b000;
        end else if (w_capture) begin
            r_rsp_result <= unit_result;
            r_rsp_flags  <= w_flags;
        end
    end

    // A clear coinciding with a capture leaves only the new flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_sticky <= 3'b000;
        else if (sticky_clr) r_sticky <= w_capture ? w_flags : 3'b000;
        else if (w_capture)  r_sticky <= r_sticky | w_flags;
    end

    assign req0_ready   = w_grant[0];
    assign req1_ready   = w_grant[1];
    assign unit_a       = r_unit_a;
    assign unit_b       = r_unit_b;
    assign unit_op      = r_unit_op;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_flags    = r_rsp_flags;
    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: two instances (UNIT_LAT 1 and 4), each fed by a
// pipelined single-precision add/sub model whose flags come from inj[].
module tb_fpu_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  vld [2];
    logic [1:0]  rdy [2];
    logic [31:0] ra [2][2];
    logic [31:0] rb [2][2];
    logic [1:0]  rop [2];
    logic        rsp_ready [2];
    logic        sclr [2];
    logic [2:0]  inj [2];
    logic [31:0] ua [2], ub [2], ures [2], rres [2];
    logic        uop [2], rv [2], rid [2], bsy [2];
    logic [2:0]  uflg [2], rflg [2], sticky [2];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          es;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        es = int'(d[62:52]) - 896;
        return {d[63], es[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        return r2sp(op ? (sp2r(a) - sp2r(b)) : (sp2r(a) + sp2r(b)));
    endfunction

    function automatic logic [31:0] rnd_sp();
        logic [7:0] e;
        e = 8'($urandom_range(100, 150));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        w_r0, w_r1;
        logic [34:0] w_dp;
        logic [34:0] pipe [1:15];

        fpu_addsub_arbiter #(.XLEN(32), .UNIT_LAT((g == 0) ? 1 : 4)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(vld[g][0]), .req1_valid(vld[g][1]),
            .req0_ready(w_r0), .req1_ready(w_r1),
            .req0_a(ra[g][0]), .req0_b(rb[g][0]), .req1_a(ra[g][1]), .req1_b(rb[g][1]),
            .req0_op(rop[g][0]), .req1_op(rop[g][1]),
            .unit_a(ua[g]), .unit_b(ub[g]), .unit_op(uop[g]),
            .unit_result(ures[g]),
            .unit_overflow(uflg[g][0]), .unit_underflow(uflg[g][1]), .unit_exception(uflg[g][2]),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rid[g]),
            .rsp_result(rres[g]), .rsp_flags(rflg[g]),
            .sticky_flags(sticky[g]), .sticky_clr(sclr[g]), .busy(bsy[g])
        );

        assign rdy[g] = {w_r1, w_r0};
        always_comb w_dp = {inj[g], dp_model(ua[g], ub[g], uop[g])};
        // Result becomes valid exactly UNIT_LAT cycles after the operands settle
        always @(posedge clk) begin
            pipe[1] <= w_dp;
            for (int k = 2; k < 16; k++) pipe[k] <= pipe[k-1];
        end
        assign {uflg[g], ures[g]} = (g == 0) ? w_dp : pipe[3];
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic grant_one(input int u, input logic [1:0] vm, output int tg, output logic [1:0] g);
        g  = 2'b00;
        tg = -100;
        vld[u] = vm;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy[u] != 2'b00) begin
                g  = rdy[u];
                tg = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        vld[u] = 2'b00;
    endtask

    task automatic wait_rsp(input int u, output int tv);
        tv = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rv[u] === 1'b1) begin
                tv = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) vld[u] = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rdy[u] !== 2'b00) begin
                errors++; $display("FAIL reset_ready[%0d]: got %b want 00", u, rdy[u]);
            end
            checks++;
            if ({ua[u], ub[u], uop[u], rid[u], rres[u], rflg[u], sticky[u], rv[u], bsy[u]} !== 106'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got a=%h b=%h op=%b id=%b res=%h fl=%b st=%b v=%b busy=%b want all 0",
                         u, ua[u], ub[u], uop[u], rid[u], rres[u], rflg[u], sticky[u], rv[u], bsy[u]);
            end
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) vld[u] = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin(input int u);
        int          n0 = 3, n1 = 3, ng = 0, nr = 0, gp;
        int          order [6];
        logic [32:0] q [$];
        logic [32:0] e;
        rsp_ready[u] = 1'b1;
        inj[u] = 3'b000;
        for (int i = 0; i < 6; i++) order[i] = -1;
        for (int p = 0; p < 2; p++) begin
            ra[u][p] = rnd_sp(); rb[u][p] = rnd_sp(); rop[u][p] = 1'($urandom_range(0, 1));
        end
        vld[u] = 2'b11;
        for (int c = 0; c < 200 && nr < 6; c++) begin
            @(negedge clk);
            gp = -1;
            if (rv[u] === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : 33'h1_DEADBEEF;
                checks++;
                if ({rid[u], rres[u]} !== e) begin
                    errors++; $display("FAIL rr_rsp[%0d] #%0d: got id=%b res=%h want id=%b res=%h",
                                       u, nr, rid[u], rres[u], e[32], e[31:0]);
                end
                nr++;
            end
            if (rdy[u] != 2'b00) begin
                gp = rdy[u][1] ? 1 : 0;
                if (ng < 6) order[ng] = gp;
                ng++;
                q.push_back({gp[0], dp_model(ra[u][gp], rb[u][gp], rop[u][gp])});
            end
            @(posedge clk); #1;
            if (gp >= 0) begin
                if (gp == 0) n0--; else n1--;
                ra[u][gp] = rnd_sp(); rb[u][gp] = rnd_sp(); rop[u][gp] = 1'($urandom_range(0, 1));
            end
            vld[u] = {n1 > 0, n0 > 0};
        end
        vld[u] = 2'b00;
        checks++;
        if (nr != 6 || ng != 6) begin
            errors++; $display("FAIL rr_count[%0d]: got grants=%0d rsps=%0d want 6 and 6", u, ng, nr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (order[i] != i % 2) begin
                errors++; $display("FAIL rr_order[%0d] slot %0d: got port %0d want %0d", u, i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_add(input int u);
        int tg, tv;
        logic [1:0] g;
        rsp_ready[u] = 1'b1; inj[u] = 3'b000;
        ra[u][0] = 32'h3F800000; rb[u][0] = 32'h40000000; rop[u][0] = 1'b0;
        grant_one(u, 2'b01, tg, g);
        wait_rsp(u, tv);
        checks++;
        if (g !== 2'b01) begin errors++; $display("FAIL add_grant[%0d]: got %b want 01", u, g); end
        checks++;
        if (tv - tg != 1 + lat(u)) begin
            errors++; $display("FAIL add_latency[%0d]: got %0d want %0d", u, tv - tg, 1 + lat(u));
        end
        checks++;
        if (rres[u] !== 32'h40400000 || rid[u] !== 1'b0) begin
            errors++; $display("FAIL add_result[%0d]: got res=%h id=%b want 40400000 id=0", u, rres[u], rid[u]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub(input int u);
        int tg, tv;
        logic [1:0] g;
        rsp_ready[u] = 1'b1; inj[u] = 3'b000;
        ra[u][1] = 32'h40400000; rb[u][1] = 32'h3F800000; rop[u][1] = 1'b1;
        grant_one(u, 2'b10, tg, g);
        wait_rsp(u, tv);
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL sub_grant[%0d]: got %b want 10", u, g); end
        checks++;
        if (tv - tg != 1 + lat(u)) begin
            errors++; $display("FAIL sub_latency[%0d]: got %0d want %0d", u, tv - tg, 1 + lat(u));
        end
        checks++;
        if (rres[u] !== 32'h40000000 || rid[u] !== 1'b1 || rflg[u] !== 3'b000) begin
            errors++; $display("FAIL sub_result[%0d]: got res=%h id=%b fl=%b want 40000000 id=1 fl=000",
                               u, rres[u], rid[u], rflg[u]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int u);
        int tg [2];
        int ng = 0;
        rsp_ready[u] = 1'b1; inj[u] = 3'b000;
        ra[u][0] = rnd_sp(); rb[u][0] = rnd_sp(); rop[u][0] = 1'b0;
        vld[u] = 2'b01;
        for (int c = 0; c < 60 && ng < 2; c++) begin
            @(negedge clk);
            if (rdy[u][0] === 1'b1) begin tg[ng] = cyc; ng++; end
            @(posedge clk); #1;
        end
        vld[u] = 2'b00;
        checks++;
        if (ng != 2 || tg[1] - tg[0] != 2 + lat(u)) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got grants=%0d gap=%0d want 2 gap=%0d",
                               u, ng, (ng == 2) ? tg[1] - tg[0] : -1, 2 + lat(u));
        end
        repeat (lat(u) + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure(input int u);
        int          tg, tv;
        logic [1:0]  g;
        logic [31:0] a, b, e;
        a = rnd_sp(); b = rnd_sp(); e = dp_model(a, b, 1'b1);
        rsp_ready[u] = 1'b0; inj[u] = 3'b101;
        ra[u][0] = a; rb[u][0] = b; rop[u][0] = 1'b1;
        grant_one(u, 2'b01, tg, g);
        vld[u] = 2'b11;
        wait_rsp(u, tv);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rv[u] !== 1'b1 || rdy[u] !== 2'b00 || bsy[u] !== 1'b1 ||
                {rid[u], rflg[u], rres[u]} !== {1'b0, 3'b101, e}) begin
                errors++;
                $display("FAIL stall[%0d] cycle %0d: got v=%b rdy=%b busy=%b id=%b fl=%b res=%h want v=1 rdy=00 busy=1 id=0 fl=101 res=%h",
                         u, i, rv[u], rdy[u], bsy[u], rid[u], rflg[u], rres[u], e);
            end
            @(posedge clk);
        end
        #1 rsp_ready[u] = 1'b1;
        @(negedge clk);
        checks++;
        if (rv[u] !== 1'b1 || rres[u] !== e) begin
            errors++; $display("FAIL stall_release[%0d]: got v=%b res=%h want v=1 res=%h", u, rv[u], rres[u], e);
        end
        @(posedge clk); #1;
        vld[u] = 2'b00;
    endtask

    task automatic test_sticky(input int u);
        int          tg, tv;
        logic [1:0]  g;
        logic [2:0]  fl [3];
        logic [2:0]  want [3];
        fl = '{3'b001, 3'b000, 3'b010};
        want = '{3'b001, 3'b001, 3'b010};
        rsp_ready[u] = 1'b1;
        sclr[u] = 1'b1;
        @(posedge clk); #1;
        sclr[u] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inj[u] = fl[k];
            ra[u][0] = rnd_sp(); rb[u][0] = rnd_sp(); rop[u][0] = 1'b0;
            grant_one(u, 2'b01, tg, g);
            if (k == 2) begin
                repeat (lat(u) - 1) begin @(posedge clk); #1; end
                sclr[u] = 1'b1;
                @(posedge clk); #1;
                sclr[u] = 1'b0;
            end
            wait_rsp(u, tv);
            checks++;
            if (tv < 0 || sticky[u] !== want[k]) begin
                errors++; $display("FAIL sticky[%0d] op %0d: got %b want %b", u, k + 1, sticky[u], want[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait(input int u);
        int         tg, tv, nv = 0;
        logic [1:0] g;
        rsp_ready[u] = 1'b1; inj[u] = 3'b100;
        ra[u][0] = rnd_sp(); rb[u][0] = rnd_sp(); rop[u][0] = 1'b0;
        grant_one(u, 2'b01, tg, g);
        @(posedge clk); #1;
        vld[u] = 2'b01;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy[u], ua[u], ub[u], uop[u], rid[u], rres[u], rflg[u], sticky[u], rv[u], bsy[u]} !== 108'd0) begin
            errors++;
            $display("FAIL midwait_reset[%0d]: got rdy=%b a=%h b=%h op=%b id=%b res=%h fl=%b st=%b v=%b busy=%b want all 0",
                     u, rdy[u], ua[u], ub[u], uop[u], rid[u], rres[u], rflg[u], sticky[u], rv[u], bsy[u]);
        end
        vld[u] = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < lat(u) + 4; c++) begin
            @(negedge clk);
            if (rv[u] !== 1'b0) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL midwait_ghost[%0d]: got %0d valid cycles want 0", u, nv); end
        @(posedge clk); #1;
        inj[u] = 3'b000;
        ra[u][0] = 32'h3F800000; rb[u][0] = 32'h40000000; rop[u][0] = 1'b0;
        ra[u][1] = rnd_sp();     rb[u][1] = rnd_sp();     rop[u][1] = 1'b1;
        grant_one(u, 2'b11, tg, g);
        wait_rsp(u, tv);
        checks++;
        if (g !== 2'b01 || tv - tg != 1 + lat(u) || rres[u] !== 32'h40400000 || rid[u] !== 1'b0) begin
            errors++; $display("FAIL midwait_next[%0d]: got grant=%b lat=%0d res=%h id=%b want 01 %0d 40400000 0",
                               u, g, tv - tg, rres[u], rid[u], 1 + lat(u));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int u);
        bit          m_busy = 1'b0;
        logic        m_last = 1'b1;
        int          m_tg = 0, gp;
        logic [31:0] m_a, m_b, m_res;
        logic        m_op, m_id;
        logic [2:0]  m_fl;
        logic [1:0]  e_rdy;
        bit          e_rv;
        vld[u] = 2'b00; rsp_ready[u] = 1'b1; inj[u] = 3'b000;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            e_rdy = 2'b00;
            if (!m_busy && vld[u] != 2'b00)
                e_rdy = (vld[u] == 2'b11) ? (m_last ? 2'b01 : 2'b10) : vld[u];
            e_rv = m_busy && (cyc - m_tg >= 1 + lat(u));
            checks++;
            if (rdy[u] !== e_rdy || rv[u] !== e_rv || bsy[u] !== m_busy) begin
                errors++; $display("FAIL rnd_ctrl[%0d] cyc %0d: got rdy=%b v=%b busy=%b want rdy=%b v=%b busy=%b",
                                   u, c, rdy[u], rv[u], bsy[u], e_rdy, e_rv, m_busy);
            end
            if (m_busy && cyc - m_tg <= lat(u)) begin
                checks++;
                if ({ua[u], ub[u], uop[u]} !== {m_a, m_b, m_op}) begin
                    errors++; $display("FAIL rnd_unit[%0d] cyc %0d: got %h %h %b want %h %h %b",
                                       u, c, ua[u], ub[u], uop[u], m_a, m_b, m_op);
                end
            end
            if (e_rv) begin
                checks++;
                if ({rid[u], rflg[u], rres[u]} !== {m_id, m_fl, m_res}) begin
                    errors++; $display("FAIL rnd_rsp[%0d] cyc %0d: got id=%b fl=%b res=%h want id=%b fl=%b res=%h",
                                       u, c, rid[u], rflg[u], rres[u], m_id, m_fl, m_res);
                end
            end
            if (e_rdy != 2'b00) begin
                gp = e_rdy[1] ? 1 : 0;
                m_busy = 1'b1; m_tg = cyc; m_last = gp[0]; m_id = gp[0];
                m_a = ra[u][gp]; m_b = rb[u][gp]; m_op = rop[u][gp];
                m_res = dp_model(m_a, m_b, m_op); m_fl = inj[u];
            end else if (e_rv && rsp_ready[u]) begin
                m_busy = 1'b0;
            end
            @(posedge clk); #1;
            vld[u] = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                ra[u][p] = rnd_sp(); rb[u][p] = rnd_sp(); rop[u][p] = 1'($urandom_range(0, 1));
            end
            rsp_ready[u] = ($urandom_range(0, 3) != 0);
            if (!m_busy) inj[u] = 3'($urandom_range(0, 7));
        end
        vld[u] = 2'b00; rsp_ready[u] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            vld[u] = 2'b00; rsp_ready[u] = 1'b1; sclr[u] = 1'b0; inj[u] = 3'b000; rop[u] = 2'b00;
            for (int p = 0; p < 2; p++) begin ra[u][p] = '0; rb[u][p] = '0; end
        end
        test_reset();
        for (int u = 0; u < 2; u++) test_round_robin(u);
        for (int u = 0; u < 2; u++) begin
            test_add(u);
            test_sub(u);
            test_back_to_back(u);
            test_backpressure(u);
            test_sticky(u);
        end
        test_reset_mid_wait(1);
        for (int u = 0; u < 2; u++) test_random(u);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
